// File: rtl/stopwatch_bcd_counter.sv
// MM.SS.hh stopwatch engine: a prescaler turns the system clock into a TICK_HZ tick
// that drives a six-digit BCD cascade under start/stop and clear control.
module stopwatch_bcd_counter #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TICK_HZ     = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop_in,
  input  logic        clear_in,
  output logic [23:0] bcd_data_out,
  output logic        dp_out,
  output logic        running_out,
  output logic        wrap_out
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   digits_q, digits_d;
  logic          wrap_q, wrap_d;
  logic          tick;
  logic          carry;

  // Tens-of-seconds and tens-of-minutes stop at 5; every other digit at 9.
  function automatic logic [3:0] digit_limit(input int idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_in) begin
      state_d = IDLE;
    end else if (start_stop_in) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    running_out = (state_q == RUN);
    dp_out      = (state_q == RUN);
  end

  assign tick = (state_q == RUN) && (presc_q == PRESC_MAX);

  // The prescaler only moves in RUN, so a pause keeps the partial period.
  always_comb begin
    presc_d = presc_q;
    if (clear_in)             presc_d = '0;
    else if (tick)            presc_d = '0;
    else if (state_q == RUN)  presc_d = presc_q + PW'(1);
  end

  always_comb begin
    digits_d = digits_q;
    carry    = tick;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (digits_q[i*4 +: 4] >= digit_limit(i)) begin
          digits_d[i*4 +: 4] = 4'd0;
        end else begin
          digits_d[i*4 +: 4] = digits_q[i*4 +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
    wrap_d = carry && !clear_in;
    if (clear_in) digits_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      digits_q <= digits_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bcd_data_out = digits_q;
  assign wrap_out     = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter (DIV = 10) with a cycle-level reference model
// and an expectation queue checked one cycle after each driven step.
module tb_stopwatch_bcd_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ss = 1'b0;
  logic        clr = 1'b0;
  logic [23:0] bcd_data_out;
  logic        dp_out;
  logic        running_out;
  logic        wrap_out;

  stopwatch_bcd_counter #(.CLK_FREQ_HZ(1000), .TICK_HZ(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_stop_in(ss),
    .clear_in     (clr),
    .bcd_data_out (bcd_data_out),
    .dp_out       (dp_out),
    .running_out  (running_out),
    .wrap_out     (wrap_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] bcd;
    logic        run;
    logic        wrap;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          m_state = 0;   // 0 idle, 1 run, 2 pause
  int          m_presc = 0;
  int          m_t     = 0;   // elapsed hundredths
  logic        m_wrap  = 1'b0;
  logic [23:0] pre_v;

  function automatic logic [23:0] to_bcd(input int t);
    int mm, s, h;
    mm = t / 6000;
    s  = (t / 100) % 60;
    h  = t % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic s, input logic c);
    exp_t e;
    ss  = s;
    clr = c;
    if (c) begin
      m_state = 0; m_presc = 0; m_t = 0; m_wrap = 1'b0;
    end else begin
      m_wrap = 1'b0;
      if (m_state == 1) begin
        if (m_presc == 9) begin
          m_presc = 0;
          m_t     = m_t + 1;
          if (m_t == 360000) begin
            m_t    = 0;
            m_wrap = 1'b1;
          end
        end else begin
          m_presc = m_presc + 1;
        end
      end
      if (s) m_state = (m_state == 1) ? 2 : 1;
    end
    e.bcd  = to_bcd(m_t);
    e.run  = (m_state == 1);
    e.wrap = m_wrap;
    q.push_back(e);
    @(posedge clk);
    #1;
    ss  = 1'b0;
    clr = 1'b0;
    e = q.pop_front();
    chk("bcd", bcd_data_out, e.bcd);
    chk("running", {23'b0, running_out}, {23'b0, e.run});
    chk("dp", {23'b0, dp_out}, {23'b0, e.run});
    chk("wrap", {23'b0, wrap_out}, {23'b0, e.wrap});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  // Call only while paused: digits are overwritten across one clock edge.
  task automatic preload(input int t);
    pre_v = to_bcd(t);
    force dut.digits_q = pre_v;
    m_t = t;
    cyc(1'b0, 1'b0);
    release dut.digits_q;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_bcd", bcd_data_out, 24'h000000);
    chk("rst_run", {23'b0, running_out}, 24'h0);
    chk("rst_dp", {23'b0, dp_out}, 24'h0);
    chk("rst_wrap", {23'b0, wrap_out}, 24'h0);
    rst_n = 1'b1;

    // 1: start latency and first ticks
    cyc(1'b1, 1'b0);
    chk("t1_run", {23'b0, running_out}, 24'h1);
    idle(9);
    chk("t1_e9", bcd_data_out, 24'h000000);
    cyc(1'b0, 1'b0);
    chk("t1_e10", bcd_data_out, 24'h000001);
    idle(990);
    chk("t1_100ticks", bcd_data_out, 24'h000100);

    // 2: pause keeps the partial prescaler period
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    idle(3);
    cyc(1'b1, 1'b0);
    idle(50);
    chk("t2_paused_bcd", bcd_data_out, 24'h000000);
    chk("t2_paused_dp", {23'b0, dp_out}, 24'h0);
    cyc(1'b1, 1'b0);
    idle(5);
    chk("t2_r5", bcd_data_out, 24'h000000);
    cyc(1'b0, 1'b0);
    chk("t2_r6", bcd_data_out, 24'h000001);

    // 3: seconds-to-minutes carry
    cyc(1'b1, 1'b0);
    preload(5990);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 200 && m_t != 6000; i++) cyc(1'b0, 1'b0);
    chk("t3_min_carry", bcd_data_out, 24'h010000);
    chk("t3_nowrap", {23'b0, wrap_out}, 24'h0);

    // 4: full rollover
    cyc(1'b1, 1'b0);
    preload(359990);
    cyc(1'b1, 1'b0);
    for (int i = 0; i < 200 && !m_wrap; i++) cyc(1'b0, 1'b0);
    chk("t4_bcd", bcd_data_out, 24'h000000);
    chk("t4_wrap", {23'b0, wrap_out}, 24'h1);
    chk("t4_run", {23'b0, running_out}, 24'h1);
    cyc(1'b0, 1'b0);
    chk("t4_wrap_end", {23'b0, wrap_out}, 24'h0);

    // 5: clear beats start_stop
    cyc(1'b1, 1'b0);
    preload(1234);
    cyc(1'b1, 1'b0);
    chk("t5_pre", bcd_data_out, 24'h001234);
    cyc(1'b1, 1'b1);
    chk("t5_bcd", bcd_data_out, 24'h000000);
    chk("t5_run", {23'b0, running_out}, 24'h0);
    idle(3);
    cyc(1'b1, 1'b0);
    idle(9);
    chk("t5_e9", bcd_data_out, 24'h000000);
    cyc(1'b0, 1'b0);
    chk("t5_e10", bcd_data_out, 24'h000001);

    // 6: asynchronous reset mid-period
    cyc(1'b1, 1'b0);
    preload(57);
    cyc(1'b1, 1'b0);
    idle(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_bcd", bcd_data_out, 24'h000000);
    chk("t6_run", {23'b0, running_out}, 24'h0);
    chk("t6_dp", {23'b0, dp_out}, 24'h0);
    chk("t6_wrap", {23'b0, wrap_out}, 24'h0);
    m_state = 0; m_presc = 0; m_t = 0; m_wrap = 1'b0;
    #3;
    rst_n = 1'b1;
    idle(100);
    chk("t6_hold", bcd_data_out, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
